// File: rtl/health_alarm_escalator_if.sv
// Signal bundle between the sensor front end and the alarm escalator.
// The master drives the raw flags and the acknowledge; the slave returns the warning status.
interface health_alarm_escalator_if #(
  parameter int NUM_CHANNELS = 6
) ();
  localparam int CH_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0] abnormality;
  logic                    acknowledge;
  logic [2:0]              abnormalityWarning;
  logic [CH_W-1:0]         activeChannel;
  logic [NUM_CHANNELS-1:0] alarmLatched;
  logic                    escalated;

  modport master (
    output abnormality, acknowledge,
    input  abnormalityWarning, activeChannel, alarmLatched, escalated
  );

  modport slave (
    input  abnormality, acknowledge,
    output abnormalityWarning, activeChannel, alarmLatched, escalated
  );
endinterface

// File: rtl/health_alarm_escalator.sv
// Persistence-filtered abnormality latching with a severity-coded warning.
// Alarms that go unacknowledged for too long escalate.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | nothing latched, warning 0
//  ALARM     | latched channels present, warning = max severity, timer runs
//  ESCALATED | alarm not acknowledged in time, warning 7
module health_alarm_escalator #(
  parameter int NUM_CHANNELS    = 6,
  parameter int PERSIST_CYCLES  = 3,
  parameter int ESCALATE_CYCLES = 16,
  parameter logic [3*NUM_CHANNELS-1:0] CHANNEL_SEVERITY =
    {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}
) (
  input logic clock,
  input logic reset,
  health_alarm_escalator_if.slave bus
);
  localparam int CH_W  = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W = $clog2(PERSIST_CYCLES + 1);
  localparam int TMR_W = $clog2(ESCALATE_CYCLES);

  typedef enum logic [1:0] {IDLE, ALARM, ESCALATED} stateT;

  stateT                   state;
  logic [TMR_W-1:0]        timer;
  logic [CNT_W-1:0]        cnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] latched;
  logic [2:0]              warnQ;
  logic [CH_W-1:0]         chanQ;
  logic                    escQ;

  logic [NUM_CHANNELS-1:0] qual;
  logic [NUM_CHANNELS-1:0] newSet;
  logic [NUM_CHANNELS-1:0] freshSet;
  logic [NUM_CHANNELS-1:0] clearMask;
  logic [NUM_CHANNELS-1:0] latchNext;
  logic [2:0]              sevNext;
  logic [CH_W-1:0]         idxNext;

  // Severity and winner are taken from the post-update latch set so an ack
  // that drops a channel is reflected on the same edge.
  always_comb begin
    qual      = '0;
    newSet    = '0;
    clearMask = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      qual[i]      = (cnt[i] == CNT_W'(PERSIST_CYCLES));
      newSet[i]    = bus.abnormality[i] && (cnt[i] == CNT_W'(PERSIST_CYCLES - 1));
      clearMask[i] = bus.acknowledge && !bus.abnormality[i];
    end
    latchNext = (latched & ~clearMask) | newSet;
    freshSet  = newSet & ~latched;
    sevNext   = 3'd0;
    idxNext   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (latchNext[i] && (CHANNEL_SEVERITY[3*i +: 3] > sevNext)) begin
        sevNext = CHANNEL_SEVERITY[3*i +: 3];
        idxNext = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      latched <= '0;
      warnQ   <= 3'd0;
      chanQ   <= '0;
      escQ    <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (!bus.abnormality[i]) cnt[i] <= '0;
        else if (!qual[i])       cnt[i] <= cnt[i] + CNT_W'(1);
      end
      latched <= latchNext;

      case (state)
        IDLE: begin
          if ((latched != '0) && (latchNext != '0)) begin
            state <= ALARM;
            timer <= '0;
            warnQ <= sevNext;
            chanQ <= idxNext;
          end
        end
        ALARM: begin
          if (bus.acknowledge && (latchNext == '0)) begin
            state <= IDLE;
            timer <= '0;
            warnQ <= 3'd0;
            chanQ <= '0;
          end else if (bus.acknowledge || (freshSet != '0)) begin
            timer <= '0;
            warnQ <= sevNext;
            chanQ <= idxNext;
          end else if (timer == TMR_W'(ESCALATE_CYCLES - 1)) begin
            state <= ESCALATED;
            warnQ <= 3'd7;
            escQ  <= 1'b1;
            chanQ <= idxNext;
          end else begin
            timer <= timer + TMR_W'(1);
            warnQ <= sevNext;
            chanQ <= idxNext;
          end
        end
        ESCALATED: begin
          if (bus.acknowledge) begin
            escQ  <= 1'b0;
            timer <= '0;
            if (latchNext == '0) begin
              state <= IDLE;
              warnQ <= 3'd0;
              chanQ <= '0;
            end else begin
              state <= ALARM;
              warnQ <= sevNext;
              chanQ <= idxNext;
            end
          end else begin
            chanQ <= idxNext;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          warnQ <= 3'd0;
          chanQ <= '0;
          escQ  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.abnormalityWarning = warnQ;
  assign bus.activeChannel      = chanQ;
  assign bus.alarmLatched       = latched;
  assign bus.escalated          = escQ;
endmodule

// File: tb/tb_health_alarm_escalator.sv
// Directed bench for health_alarm_escalator at default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_health_alarm_escalator;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  health_alarm_escalator_if #(.NUM_CHANNELS(6)) hif ();

  health_alarm_escalator dut (
    .clock (clock),
    .reset (reset),
    .bus   (hif)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkAll(input string tag, input int warn, input int chan,
                          input int lat, input int esc);
    checkVal({tag, ".warn"}, int'(hif.abnormalityWarning), warn);
    checkVal({tag, ".chan"}, int'(hif.activeChannel), chan);
    checkVal({tag, ".latch"}, int'(hif.alarmLatched), lat);
    checkVal({tag, ".esc"}, int'(hif.escalated), esc);
  endtask

  initial begin
    hif.abnormality = '0;
    hif.acknowledge = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    checkAll("rst", 0, 0, 0, 0);

    // glitch of two cycles is rejected
    hif.abnormality = 6'b000100;
    tick(2);
    hif.abnormality = '0;
    tick(2);
    checkAll("glitch", 0, 0, 0, 0);

    // held channel 2: latch at edge 3, warning at edge 4
    hif.abnormality = 6'b000100;
    tick(2);
    checkVal("ch2.e2.latch", int'(hif.alarmLatched), 0);
    tick(1);
    checkAll("ch2.e3", 0, 0, 6'b000100, 0);
    tick(1);
    checkAll("ch2.e4", 3, 2, 6'b000100, 0);
    hif.abnormality = '0;
    hif.acknowledge = 1'b1;
    tick(1);
    hif.acknowledge = 1'b0;
    checkAll("ch2.clr", 0, 0, 0, 0);

    // channels 1 and 4, then 4 drops and is acknowledged away
    hif.abnormality = 6'b010010;
    tick(4);
    checkAll("c14", 5, 4, 6'b010010, 0);
    hif.abnormality = 6'b000010;
    tick(1);
    checkVal("c14.drop.warn", int'(hif.abnormalityWarning), 5);
    hif.acknowledge = 1'b1;
    tick(1);
    hif.acknowledge = 1'b0;
    checkAll("c1.ack", 2, 1, 6'b000010, 0);
    hif.abnormality = '0;
    hif.acknowledge = 1'b1;
    tick(1);
    hif.acknowledge = 1'b0;
    checkAll("c1.clr", 0, 0, 0, 0);

    // channel 0 escalates 16 edges after ALARM entry
    hif.abnormality = 6'b000001;
    tick(4);
    checkAll("esc.entry", 1, 0, 6'b000001, 0);
    tick(15);
    checkAll("esc.e15", 1, 0, 6'b000001, 0);
    tick(1);
    checkAll("esc.e16", 7, 0, 6'b000001, 1);
    hif.acknowledge = 1'b1;
    tick(1);
    hif.acknowledge = 1'b0;
    checkAll("esc.ackHigh", 1, 0, 6'b000001, 0);
    hif.abnormality = '0;
    hif.acknowledge = 1'b1;
    tick(1);
    hif.acknowledge = 1'b0;
    checkAll("esc.ackLow", 0, 0, 0, 0);

    // qualification coinciding with acknowledge: set wins
    hif.abnormality = 6'b001000;
    tick(2);
    hif.acknowledge = 1'b1;
    tick(1);
    hif.acknowledge = 1'b0;
    checkVal("ch3.same.latch", int'(hif.alarmLatched), 6'b001000);
    tick(1);
    checkAll("ch3.alarm", 4, 3, 6'b001000, 0);

    // async reset between edges while in ALARM
    #3;
    reset = 1'b1;
    #1;
    checkAll("asyncRst", 0, 0, 0, 0);
    hif.abnormality = '0;
    tick(1);
    reset = 1'b0;
    tick(2);
    checkAll("postRst", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
